// File: rtl/reply_serializer.sv
// rtl/reply_serializer.sv - frames one tagged reply request as header, length, payload bytes on the host byte interface
module reply_serializer #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_tag,
  input  logic [3:0]             req_len,
  input  logic [8*MAX_BYTES-1:0] req_data,
  output logic                   reply_rdy,
  output logic [7:0]             reply,
  input  logic                   reply_ack,
  output logic                   reply_end,
  output logic                   len_err,
  output logic [7:0]             frames_sent
);

  typedef enum logic [1:0] {IDLE, HDR, LEN, PAY} state_t;

  localparam logic [3:0] MAX_L = 4'(MAX_BYTES);

  state_t                 state_q, state_d;
  logic [3:0]             len_q, len_d;
  logic [3:0]             idx_q, idx_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic [7:0]             reply_d, frames_d;
  logic                   rdy_d, end_d, ready_d, err_d;
  logic                   advance, done;

  function automatic logic [7:0] pick(input logic [8*MAX_BYTES-1:0] d, input logic [3:0] i);
    return d[8*int'(i) +: 8];
  endfunction

  // A byte only moves when the host acks a byte that is actually on offer.
  assign advance = reply_rdy & reply_ack;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    data_d   = data_q;
    reply_d  = reply;
    frames_d = frames_sent;
    rdy_d    = reply_rdy;
    end_d    = reply_end;
    ready_d  = req_ready;
    err_d    = len_err;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = HDR;
          len_d   = (req_len > MAX_L) ? MAX_L : req_len;
          data_d  = req_data;
          err_d   = len_err | (req_len > MAX_L);
          reply_d = req_tag;
          rdy_d   = 1'b1;
          end_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      HDR: begin
        if (advance) begin
          state_d = LEN;
          reply_d = {4'd0, len_q};
          end_d   = (len_q == 4'd0);
        end
      end
      LEN: begin
        if (advance) begin
          if (len_q == 4'd0) begin
            done = 1'b1;
          end else begin
            state_d = PAY;
            idx_d   = 4'd0;
            reply_d = pick(data_q, 4'd0);
            end_d   = (len_q == 4'd1);
          end
        end
      end
      PAY: begin
        if (advance) begin
          if (idx_q == len_q - 4'd1) begin
            done = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            reply_d = pick(data_q, idx_q + 4'd1);
            end_d   = (idx_q + 4'd2 == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion leaves one idle cycle with reply_rdy low before any next header.
    if (done) begin
      state_d  = IDLE;
      rdy_d    = 1'b0;
      end_d    = 1'b0;
      reply_d  = 8'd0;
      ready_d  = 1'b1;
      frames_d = frames_sent + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= 4'd0;
      idx_q       <= 4'd0;
      data_q      <= '0;
      reply       <= 8'd0;
      frames_sent <= 8'd0;
      reply_rdy   <= 1'b0;
      reply_end   <= 1'b0;
      req_ready   <= 1'b1;
      len_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      reply       <= reply_d;
      frames_sent <= frames_d;
      reply_rdy   <= rdy_d;
      reply_end   <= end_d;
      req_ready   <= ready_d;
      len_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_reply_serializer.sv
// tb/tb_reply_serializer.sv - directed, table-driven bench for reply_serializer
module tb_reply_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_tag = 8'd0;
  logic [3:0]  req_len = 4'd0;
  logic [63:0] req_data = 64'd0;
  logic        reply_rdy;
  logic [7:0]  reply;
  logic        reply_ack = 1'b0;
  logic        reply_end;
  logic        len_err;
  logic [7:0]  frames_sent;

  int errors = 0;
  int checks = 0;

  reply_serializer #(.MAX_BYTES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_len(req_len), .req_data(req_data),
    .reply_rdy(reply_rdy), .reply(reply), .reply_ack(reply_ack),
    .reply_end(reply_end), .len_err(len_err), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [3:0]  len;
    logic [63:0] data;
    int          gap;
    int          n;
    logic [79:0] exp;
    logic        err;
    logic [7:0]  frames;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int         wait_c;
    int         g;
    logic [7:0] b0;
    logic       e0;
    logic       stable;
    req_tag   = v.tag;
    req_len   = v.len;
    req_data  = v.data;
    req_valid = 1'b1;
    wait_c    = 0;
    while (!req_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    chk("req_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_tag   = ~v.tag;
    req_data  = ~v.data;
    for (int i = 0; i < v.n; i++) begin
      g      = (v.gap > 0) ? int'($urandom_range(0, v.gap)) : 0;
      b0     = reply;
      e0     = reply_end;
      stable = 1'b1;
      chk("reply_rdy_in_frame", 32'(reply_rdy), 32'd1);
      repeat (g) begin
        reply_ack = 1'b0;
        @(negedge clk);
        if (reply !== b0 || reply_end !== e0 || reply_rdy !== 1'b1) stable = 1'b0;
      end
      chk("reply_byte", 32'(reply), 32'(v.exp[8*i +: 8]));
      chk("reply_end", 32'(reply_end), 32'(i == v.n - 1));
      chk("stall_stable", 32'(stable), 32'd1);
      reply_ack = 1'b1;
      @(negedge clk);
    end
    reply_ack = 1'b0;
    chk("done_rdy_low", 32'(reply_rdy), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
    chk("frames_sent", 32'(frames_sent), 32'(v.frames));
    chk("len_err", 32'(len_err), 32'(v.err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    vecs[0] = '{8'h5A, 4'd3,  64'h0000_0000_0033_2211, 0, 5,  80'h0000_0000_0033_2211_035A, 1'b0, 8'd1};
    vecs[1] = '{8'hC3, 4'd0,  64'h0000_0000_0000_00FF, 0, 2,  80'h0000_0000_0000_0000_00C3, 1'b0, 8'd2};
    vecs[2] = '{8'h7E, 4'd12, 64'h0807_0605_0403_0201, 0, 10, 80'h0807_0605_0403_0201_087E, 1'b1, 8'd3};
    vecs[3] = '{8'h99, 4'd2,  64'h0000_0000_0000_BBAA, 2, 4,  80'h0000_0000_0000_BBAA_0299, 1'b1, 8'd4};
    vecs[4] = '{8'h3C, 4'd4,  64'h0000_0000_7766_5544, 5, 6,  80'h0000_0000_7766_5544_043C, 1'b1, 8'd5};
    vecs[5] = '{8'h21, 4'd1,  64'h0000_0000_0000_005E, 1, 3,  80'h0000_0000_0000_005E_0121, 1'b0, 8'd1};

    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_reply_rdy", 32'(reply_rdy), 32'd0);
    chk("rst_reply", 32'(reply), 32'd0);
    chk("rst_reply_end", 32'(reply_end), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_frame(vecs[t]);

    // Acks while idle must not start or advance anything.
    reply_ack = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (reply_rdy !== 1'b0) bad++;
    end
    reply_ack = 1'b0;
    chk("idle_ack_rdy", 32'(bad), 32'd0);
    chk("idle_ack_frames", 32'(frames_sent), 32'd5);

    // Reset right after the length byte is acked.
    req_tag = 8'h10; req_len = 4'd3; req_data = 64'h0000_0000_00CC_BBAA; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_hdr", 32'(reply), 32'h10);
    reply_ack = 1'b1;
    @(negedge clk);
    chk("mid_len", 32'(reply), 32'h03);
    @(negedge clk);
    reply_ack = 1'b0;
    chk("mid_pay0", 32'(reply), 32'hAA);
    reset = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_reply_rdy", 32'(reply_rdy), 32'd0);
    chk("arst_reply", 32'(reply), 32'd0);
    chk("arst_reply_end", 32'(reply_end), 32'd0);
    chk("arst_len_err", 32'(len_err), 32'd0);
    chk("arst_frames", 32'(frames_sent), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(vecs[5]);

    // 256 back-to-back single-byte frames: period of 4 cycles, one idle gap each.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_tag = 8'hA5; req_len = 4'd1; req_data = 64'h77; req_valid = 1'b1;
    reply_ack = 1'b1;
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      if (reply_rdy !== (k % 4 != 0)) bad++;
      if (k == 1020) chk("frames_255", 32'(frames_sent), 32'd255);
      @(negedge clk);
    end
    req_valid = 1'b0;
    reply_ack = 1'b0;
    chk("gap_pattern", 32'(bad), 32'd0);
    chk("frames_wrap", 32'(frames_sent), 32'd0);
    chk("wrap_idle_rdy", 32'(reply_rdy), 32'd0);
    @(negedge clk);
    chk("wrap_no_accept", 32'(reply_rdy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
